// File: rtl/memory_bus_controller_pkg.sv
// Shared types for the core-to-bank-RAM memory bus controller: bank map,
// access kinds, exception mask layout and controller FSM states.
package memory_bus_controller_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned RAM_ADDR_W_DEF = 10;

    localparam logic [3:0] MMU_BANK_INST = 4'h0;
    localparam logic [3:0] MMU_BANK_DATA = 4'h1;

    localparam int unsigned MEM_EXC_MISALIGNED_BIT = 0;
    localparam int unsigned MEM_EXC_UNMAPPED_BIT   = 1;

    typedef enum logic [2:0] {
        MEM_ACC_WORD   = 3'd0,
        MEM_ACC_HALF   = 3'd1,
        MEM_ACC_HALF_U = 3'd2,
        MEM_ACC_BYTE   = 3'd3,
        MEM_ACC_BYTE_U = 3'd4
    } mem_access_t;

    typedef struct packed {
        logic unmapped;
        logic misaligned;
    } mem_exception_mask_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_WAIT = 3'd1,
        ST_RMW_WAIT  = 3'd2,
        ST_RMW_WRITE = 3'd3,
        ST_RESP      = 3'd4
    } mem_bus_state_t;

    // Byte accesses are always aligned; halves need an even address, words a multiple of 4.
    function automatic logic is_aligned(input mem_access_t acc, input logic [1:0] off);
        case (acc)
            MEM_ACC_HALF, MEM_ACC_HALF_U: return ~off[0];
            MEM_ACC_WORD:                 return (off == 2'b00);
            default:                      return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/memory_bus_controller_byte_lane.sv
// Byte-lane helpers: load lane select with sign/zero extension, and sub-word
// store merge into a full RAM word.
module byte_lane_unit
    import memory_bus_controller_pkg::*;
(
    input  mem_access_t     i_access,
    input  logic [1:0]      i_offset,
    input  logic [XLEN-1:0] i_rd_word,
    input  logic [XLEN-1:0] i_wr_data,
    output logic [XLEN-1:0] o_load_data_c,
    output logic [XLEN-1:0] o_merged_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rd_word[7:0];
        case (i_offset)
            2'd1:    w_byte = i_rd_word[15:8];
            2'd2:    w_byte = i_rd_word[23:16];
            2'd3:    w_byte = i_rd_word[31:24];
            default: w_byte = i_rd_word[7:0];
        endcase
        w_half = i_offset[1] ? i_rd_word[31:16] : i_rd_word[15:0];

        case (i_access)
            MEM_ACC_BYTE:   o_load_data_c = {{24{w_byte[7]}}, w_byte};
            MEM_ACC_BYTE_U: o_load_data_c = {24'h000000, w_byte};
            MEM_ACC_HALF:   o_load_data_c = {{16{w_half[15]}}, w_half};
            MEM_ACC_HALF_U: o_load_data_c = {16'h0000, w_half};
            default:        o_load_data_c = i_rd_word;
        endcase
    end

    // Only the low byte/half of the store operand lands in the addressed lane.
    always_comb begin
        o_merged_c = i_rd_word;
        case (i_access)
            MEM_ACC_BYTE, MEM_ACC_BYTE_U: begin
                case (i_offset)
                    2'd1:    o_merged_c[15:8]  = i_wr_data[7:0];
                    2'd2:    o_merged_c[23:16] = i_wr_data[7:0];
                    2'd3:    o_merged_c[31:24] = i_wr_data[7:0];
                    default: o_merged_c[7:0]   = i_wr_data[7:0];
                endcase
            end
            MEM_ACC_HALF, MEM_ACC_HALF_U: begin
                if (i_offset[1]) o_merged_c[31:16] = i_wr_data[15:0];
                else             o_merged_c[15:0]  = i_wr_data[15:0];
            end
            default: o_merged_c = i_wr_data;
        endcase
    end

endmodule

// File: rtl/memory_bus_controller.sv
// Memory bus controller between the multicycle core and the instruction/data
// bank RAMs: bank decode, alignment check, RMW sub-word stores, extended loads.
module memory_bus_controller
    import memory_bus_controller_pkg::*;
#(
    parameter int unsigned RAM_ADDR_W = RAM_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_core_valid,
    input  logic [XLEN-1:0]       i_core_addr,
    input  logic [XLEN-1:0]       i_core_wr_data,
    input  logic                  i_core_wr_ena,
    input  mem_access_t           i_core_access,
    output logic                  o_core_ready,
    output logic [XLEN-1:0]       o_core_rd_data,
    output mem_exception_mask_t   o_core_exception,
    output logic [RAM_ADDR_W-1:0] o_ram_addr,
    output logic                  o_ram_inst_sel,
    output logic                  o_ram_data_sel,
    output logic                  o_ram_wr_ena,
    output logic [XLEN-1:0]       o_ram_wr_data,
    input  logic [XLEN-1:0]       i_ram_inst_rd_data,
    input  logic [XLEN-1:0]       i_ram_data_rd_data
);

    mem_bus_state_t          r_state;
    logic [RAM_ADDR_W+1:0]   r_addr;
    logic [XLEN-1:0]         r_wr_data;
    mem_access_t             r_access;
    logic                    r_is_inst;
    logic [XLEN-1:0]         r_merged;

    logic [3:0]              w_bank;
    logic                    w_bank_inst;
    logic                    w_bank_data;
    logic [1:0]              w_exc_bits;
    logic                    w_exc_any;
    logic                    w_accept;
    logic                    w_store_word;
    logic                    w_sel;
    logic                    w_sel_inst;
    logic [XLEN-1:0]         w_ram_rd;
    logic [XLEN-1:0]         w_load_data;
    logic [XLEN-1:0]         w_merged;
    logic                    w_unused_addr;

    // Bits between the word index and the bank nibble alias within a bank.
    assign w_unused_addr = ^i_core_addr[XLEN-5:RAM_ADDR_W+2];

    assign w_bank      = i_core_addr[XLEN-1:XLEN-4];
    assign w_bank_inst = (w_bank == MMU_BANK_INST);
    assign w_bank_data = (w_bank == MMU_BANK_DATA);

    always_comb begin
        w_exc_bits = 2'b00;
        w_exc_bits[MEM_EXC_MISALIGNED_BIT] = ~is_aligned(i_core_access, i_core_addr[1:0]);
        w_exc_bits[MEM_EXC_UNMAPPED_BIT]   = ~(w_bank_inst | w_bank_data);
    end

    assign w_exc_any    = |w_exc_bits;
    assign w_accept     = (r_state == ST_IDLE) && i_core_valid && !rst && !w_exc_any;
    assign w_store_word = i_core_wr_ena && (i_core_access == MEM_ACC_WORD);
    assign w_ram_rd     = r_is_inst ? i_ram_inst_rd_data : i_ram_data_rd_data;

    byte_lane_unit u_lane (
        .i_access      (r_access),
        .i_offset      (r_addr[1:0]),
        .i_rd_word     (w_ram_rd),
        .i_wr_data     (r_wr_data),
        .o_load_data_c (w_load_data),
        .o_merged_c    (w_merged)
    );

    // RAM side: driven straight from the live request in IDLE, from the held copy afterwards.
    always_comb begin
        o_ram_addr    = r_addr[RAM_ADDR_W+1:2];
        o_ram_wr_ena  = 1'b0;
        o_ram_wr_data = r_merged;
        w_sel         = 1'b0;
        w_sel_inst    = r_is_inst;
        if (w_accept) begin
            o_ram_addr = i_core_addr[RAM_ADDR_W+1:2];
            w_sel      = 1'b1;
            w_sel_inst = w_bank_inst;
            if (w_store_word) begin
                o_ram_wr_ena  = 1'b1;
                o_ram_wr_data = i_core_wr_data;
            end
        end else if (r_state == ST_RMW_WRITE) begin
            w_sel        = 1'b1;
            o_ram_wr_ena = 1'b1;
        end
        o_ram_inst_sel = w_sel & w_sel_inst;
        o_ram_data_sel = w_sel & ~w_sel_inst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            o_core_ready     <= 1'b0;
            o_core_rd_data   <= '0;
            o_core_exception <= '0;
            r_addr           <= '0;
            r_wr_data        <= '0;
            r_access         <= MEM_ACC_WORD;
            r_is_inst        <= 1'b0;
            r_merged         <= '0;
        end else begin
            o_core_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_core_valid) begin
                        r_addr           <= i_core_addr[RAM_ADDR_W+1:0];
                        r_wr_data        <= i_core_wr_data;
                        r_access         <= i_core_access;
                        r_is_inst        <= w_bank_inst;
                        o_core_rd_data   <= '0;
                        o_core_exception <= mem_exception_mask_t'(w_exc_bits);
                        if (w_exc_any || w_store_word) begin
                            o_core_ready <= 1'b1;
                            r_state      <= ST_RESP;
                        end else if (!i_core_wr_ena) begin
                            r_state <= ST_LOAD_WAIT;
                        end else begin
                            r_state <= ST_RMW_WAIT;
                        end
                    end
                end
                ST_LOAD_WAIT: begin
                    o_core_rd_data <= w_load_data;
                    o_core_ready   <= 1'b1;
                    r_state        <= ST_RESP;
                end
                ST_RMW_WAIT: begin
                    r_merged <= w_merged;
                    r_state  <= ST_RMW_WRITE;
                end
                ST_RMW_WRITE: begin
                    o_core_ready <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/memory_bus_controller.md
Name: memory_bus_controller

Overview:
- Sits directly downstream of the multicycle core's memory interface. Sits between the core and the instruction and data bank RAMs.
- Decodes the bank nibble (addr[31:28]) and checks alignment for the requested access.
- Performs sub-word stores as read-modify-write (RMW) into word-wide RAMs with no byte enables.
- Returns sign- or zero-extended load data to the core over a valid/ready handshake.

Parameters:
- RAM_ADDR_W, 10, word-address width of each bank RAM (4 KiB per bank).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- core_valid  in  1  request present; core holds it and all request fields stable until core_ready
- core_addr  in  32  byte address
- core_wr_data  in  32  store data; the operand occupies the low bits
- core_wr_ena  in  1  1 = store, 0 = load
- core_access  in  mem_access_t  byte/half/word, signed/unsigned
- core_ready  out  1  one-cycle completion pulse
- core_rd_data  out  32  extended load data; valid while core_ready=1
- core_exception  out  mem_exception_mask_t  valid while core_ready=1
- ram_addr  out  RAM_ADDR_W  word index = core_addr[RAM_ADDR_W+1:2]
- ram_inst_sel  out  1  select instruction-bank RAM
- ram_data_sel  out  1  select data-bank RAM
- ram_wr_ena  out  1  write strobe; asserted for exactly one cycle per store
- ram_wr_data  out  32  full word to write
- ram_inst_rd_data  in  32  instruction RAM synchronous read data (1-cycle latency)
- ram_data_rd_data  in  32  data RAM synchronous read data (1-cycle latency)

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values:
  - state=IDLE
  - core_ready=0, core_rd_data=0, core_exception=0
  - ram_wr_ena=0, ram_inst_sel=0, ram_data_sel=0
- RAM-side outputs are combinational from state and the held request. core_* outputs are registered.
- Bank decode:
  - MMU_BANK_INST → inst RAM.
  - MMU_BANK_DATA → data RAM.
  - Any other bank → unmapped.
  - Address bits above RAM_ADDR_W+1 within a bank are ignored (alias).
- Alignment rules:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Byte is always aligned.
- FSM states: IDLE, LOAD_WAIT, RMW_WAIT, RMW_WRITE, RESP.
- IDLE with core_valid=0: all ram strobes 0; state stays IDLE.
- IDLE with core_valid=1, taking the first matching case:
  - Misaligned or unmapped → RESP with the misaligned and/or unmapped bit set (both may be set); rd_data=0; no RAM access.
  - Load → assert the bank select → LOAD_WAIT.
  - Word store → assert the bank select and ram_wr_ena, ram_wr_data=core_wr_data → RESP.
  - Sub-word store → assert the bank select (read) → RMW_WAIT.
- LOAD_WAIT:
  - Select the lane using addr[1:0].
  - Extend per core_access: signed variants sign-extend from bit 7 or 15; unsigned variants zero-extend.
  - Register the result into core_rd_data → RESP.
- RMW_WAIT:
  - Merge the low byte or half of core_wr_data into the read word at lane addr[1:0].
  - Store the merged word in an internal register → RMW_WRITE.
- RMW_WRITE: bank select=1, ram_wr_ena=1, ram_wr_data=merged word → RESP.
- RESP:
  - core_ready=1 for exactly this cycle.
  - core_exception holds the captured mask.
  - core_valid is ignored → IDLE. The next request is accepted no earlier than the following cycle.
- Latency from core_valid sampled in IDLE to the core_ready cycle:
  - Exception or word store: 1 cycle.
  - Load: 2 cycles.
  - Sub-word store: 3 cycles.
- Each store produces exactly one write; loads never write.
- core_valid deasserted mid-transaction is a protocol violation; the FSM still completes.
- Reset mid-operation: return to IDLE immediately. An RMW aborted in RMW_WAIT performs no write, and the RAM word stays unchanged.
- core_rd_data is 0 for stores and exceptions.

Decomposition:
- Extend the shared package (memory_map.sv / memory_exceptions.sv) with:
  - the bank-nibble constants already used;
  - a mem_bus_state_t enum;
  - misaligned/unmapped bit positions, if not already present.
- One combinational sub-module, byte_lane_unit, provides both helpers:
  - load lane select plus extend;
  - store merge.

Test Plan:
1. Word store then load: store 0xDEADBEEF to 0x1000_0010, then load word → ram_wr_ena for 1 cycle at ram_addr=4; load returns 0xDEADBEEF with ready 2 cycles after valid.
2. Signed/unsigned byte loads: word 0x80FF7F01 at 0x1000_0020; LB at +3 → 0xFFFFFF80; LBU at +3 → 0x00000080; LH at +0 → 0x00007F01; LHU at +2 → 0x000080FF.
3. Sub-word store RMW: word 0x11223344, SB 0xAA to offset 1 → word becomes 0x1122AA44; write occurs in the 3rd cycle; ready in the 4th.
4. Exceptions:
   - LW at 0x1000_0002 → misaligned bit set, ready 1 cycle after valid, no RAM access.
   - SW at 0x7000_0000 → unmapped bit set, ram_wr_ena never high.
   - SH at 0x7000_0001 → both bits set.
5. Reset mid-RMW: assert rst while in RMW_WAIT → outputs go to reset values asynchronously; target word unchanged on readback.
6. Back-to-back requests: core_valid held high across two queued requests → each gets exactly one core_ready pulse, and the second request is accepted only after the RESP cycle.
